// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared defaults and element types for the integer register file
package regfile_mp_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int AW_DEFAULT   = 5;

  typedef logic [XLEN_DEFAULT-1:0] word_t;
  typedef logic [AW_DEFAULT-1:0]   addr_t;
  typedef addr_t                   regidx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write busy bits with reserve/release priority and per-port lookup
module regfile_scoreboard #(
  parameter int AW          = 5,
  parameter int NR          = 2,
  parameter int NW          = 1,
  parameter bit BYPASS      = 1'b1,
  parameter bit DBG_RELEASE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR*AW-1:0] rs_addr,
  output logic [NR-1:0]    rs_busy,
  input  logic [NW-1:0]    rd_en,
  input  logic [NW*AW-1:0] rd_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] rel, rsv;

  // Reserve is applied after release so a new producer supersedes the retiring one.
  always_comb begin
    rel = '0;
    rsv = '0;
    for (int j = 0; j < NW; j++) begin
      if (rd_en[j] && rd_addr[j*AW +: AW] != '0) begin
        rel[rd_addr[j*AW +: AW]] = 1'b1;
      end
    end
    if (rsv_en && rsv_addr != '0) begin
      rsv[rsv_addr] = 1'b1;
    end
    busy_d = (busy_q & ~rel) | rsv;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs_busy = '0;
    for (int i = 0; i < NR; i++) begin
      rs_busy[i] = busy_q[rs_addr[i*AW +: AW]] &&
                   !(BYPASS && rel[rs_addr[i*AW +: AW]] && !rsv[rs_addr[i*AW +: AW]]);
    end
  end

  if (DBG_RELEASE) begin : g_dbg_release
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int r = 1; r < DEPTH; r++) begin
          assert (!(rel[r] && !busy_q[r]))
            else $warning("regfile_scoreboard: release of non-busy register %0d", r);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port integer register file with bypass and pending-write scoreboard
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int AW          = AW_DEFAULT,
  parameter int NR          = 2,
  parameter int NW          = 1,
  parameter bit BYPASS      = 1'b1,
  parameter bit DBG_RELEASE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NR*AW-1:0]   rs_addr,
  output logic [NR*XLEN-1:0] rs_data,
  output logic [NR-1:0]      rs_busy,
  input  logic [NW-1:0]      rd_en,
  input  logic [NW*AW-1:0]   rd_addr,
  input  logic [NW*XLEN-1:0] rd_data,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr
);
  localparam int DEPTH = 1 << AW;

  if (NW < 1 || NW > 4) begin : g_bad_nw
    $error("regfile_mp: NW must be in 1..4");
  end
  if (AW < 1) begin : g_bad_aw
    $error("regfile_mp: AW must be at least 1");
  end
  if (XLEN < 1) begin : g_bad_xlen
    $error("regfile_mp: XLEN must be at least 1");
  end

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [DEPTH];

  // Ascending port order lets the highest-index writer win for both storage and bypass.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      wr_val[r] = '0;
    end
    for (int j = 0; j < NW; j++) begin
      if (rd_en[j] && rd_addr[j*AW +: AW] != '0) begin
        wr_hit[rd_addr[j*AW +: AW]] = 1'b1;
        wr_val[rd_addr[j*AW +: AW]] = rd_data[j*XLEN +: XLEN];
      end
    end
    valid_d = valid_q | wr_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Storage itself is never cleared; the valid bits provide the flash clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 1; r < DEPTH; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
    end
  end

  always_comb begin
    rs_data = '0;
    for (int i = 0; i < NR; i++) begin
      if (BYPASS && wr_hit[rs_addr[i*AW +: AW]]) begin
        rs_data[i*XLEN +: XLEN] = wr_val[rs_addr[i*AW +: AW]];
      end else if (valid_q[rs_addr[i*AW +: AW]]) begin
        rs_data[i*XLEN +: XLEN] = regs_q[rs_addr[i*AW +: AW]];
      end
    end
  end

  regfile_scoreboard #(
    .AW          (AW),
    .NR          (NR),
    .NW          (NW),
    .BYPASS      (BYPASS),
    .DBG_RELEASE (DBG_RELEASE)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (rs_addr),
    .rs_busy  (rs_busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, bypass and non-bypass builds side by side
module tb_regfile_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic [9:0]  rs_addr  = '0;
  logic [1:0]  rd_en    = '0;
  logic [9:0]  rd_addr  = '0;
  logic [63:0] rd_data  = '0;
  logic        rsv_en   = 1'b0;
  logic [4:0]  rsv_addr = '0;

  logic [63:0] rs_data_b, rs_data_n;
  logic [1:0]  rs_busy_b, rs_busy_n;

  regfile_mp #(.XLEN(32), .AW(5), .NR(2), .NW(2), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  regfile_mp #(.XLEN(32), .AW(5), .NR(2), .NW(2), .BYPASS(1'b0)) u_dut_nob (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  typedef struct {
    int          cyc;
    logic [63:0] db;
    logic [63:0] dn;
    logic [1:0]  bb;
    logic [1:0]  bn;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("data_bypass",  e.cyc, rs_data_b, e.db);
      check("data_nobypass", e.cyc, rs_data_n, e.dn);
      check("busy_bypass",  e.cyc, {62'd0, rs_busy_b}, {62'd0, e.bb});
      check("busy_nobypass", e.cyc, {62'd0, rs_busy_n}, {62'd0, e.bn});
    end
  end

  // One clock of stimulus: expected outputs come from the pre-edge model, then the model takes the edge.
  task automatic step(input logic rst, input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1, input logic rv, input logic [4:0] ra,
                      input logic [4:0] s0, input logic [4:0] s1, input logic chk);
    exp_t        e;
    logic [4:0]  a;
    logic [31:0] stored, byp;
    logic        hit, rsv_hit, bsy;
    @(posedge clk);
    #1;
    reset = rst; rd_en = en; rd_addr = {a1, a0}; rd_data = {d1, d0};
    rsv_en = rv; rsv_addr = ra; rs_addr = {s1, s0};
    e.cyc = cyc;
    for (int p = 0; p < 2; p++) begin
      a       = (p == 0) ? s0 : s1;
      stored  = (a == 0) ? 32'd0 : m_mem[a];
      byp     = stored;
      hit     = 1'b0;
      if (en[0] && a0 == a && a != 0) begin byp = d0; hit = 1'b1; end
      if (en[1] && a1 == a && a != 0) begin byp = d1; hit = 1'b1; end
      rsv_hit = rv && ra == a && a != 0;
      bsy     = (a != 0) && m_busy[a];
      e.db[p*32 +: 32] = byp;
      e.dn[p*32 +: 32] = stored;
      e.bn[p] = bsy;
      e.bb[p] = bsy && !(hit && !rsv_hit);
    end
    if (chk) exp_q.push_back(e);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_mem[r] = 32'd0; m_busy[r] = 1'b0; end
    end else begin
      if (en[0] && a0 != 0) begin m_mem[a0] = d0; m_busy[a0] = 1'b0; end
      if (en[1] && a1 != 0) begin m_mem[a1] = d1; m_busy[a1] = 1'b0; end
      if (rv && ra != 0) m_busy[ra] = 1'b1;
    end
    cyc++;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin m_mem[r] = 32'd0; m_busy[r] = 1'b0; end
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset clears a written register
    step(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 5, 1);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5, 1);
    // basic write alongside an ignored x0 write
    step(0, 2'b11, 3, 32'h12345678, 0, 32'hFFFFFFFF, 0, 0, 3, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    // bypass versus pre-write value
    step(0, 2'b01, 7, 32'h1, 0, 0, 0, 0, 7, 7, 1);
    step(0, 2'b01, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 7, 7, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7, 1);
    // same-address write conflict
    step(0, 2'b11, 9, 32'h11, 9, 32'h22, 0, 0, 9, 9, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 9, 1);
    // scoreboard reserve / release / collision / x0
    step(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 4, 1);
    step(0, 2'b01, 4, 32'h55, 0, 0, 0, 0, 4, 4, 1);
    step(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 4, 1);
    step(0, 2'b01, 4, 32'h66, 0, 0, 1, 4, 4, 4, 1);
    step(0, 2'b00, 0, 0, 0, 0, 1, 0, 4, 0, 1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0, 1);
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
           rnd_addr(), $urandom(), rnd_addr(), $urandom(),
           1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr(), 1);
    end
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain remaining=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
